// File: rtl/keypad_emulator.sv
// Device-side model of the 4x4 PmodKYPD keypad: presses a requested key for HOLD_SCANS
// decoder scans, releases it for GAP_SCANS scans, then pulses done.
module keypad_emulator #(
    parameter int unsigned HOLD_SCANS = 4,
    parameter int unsigned GAP_SCANS  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] PAT1 = 4'b0111;
    localparam logic [3:0] PAT2 = 4'b1011;
    localparam logic [3:0] PAT3 = 4'b1101;
    localparam logic [3:0] PAT4 = 4'b1110;
    localparam logic [7:0] HOLD_CNT = 8'(HOLD_SCANS);
    localparam logic [7:0] GAP_CNT  = 8'(GAP_SCANS);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0] col_prev_q;
    logic [3:0] tcol_q, tcol_d, trow_q, trow_d;
    logic [3:0] row_q, row_d;
    logic       ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic       scan_start;

    // Returns {column pattern, row pattern} of a key on the PmodKYPD layout.
    function automatic logic [7:0] key_map(input logic [3:0] k);
        logic [7:0] m;
        case (k)
            4'h1: m = {PAT1, PAT1};
            4'h4: m = {PAT1, PAT2};
            4'h7: m = {PAT1, PAT3};
            4'h0: m = {PAT1, PAT4};
            4'h2: m = {PAT2, PAT1};
            4'h5: m = {PAT2, PAT2};
            4'h8: m = {PAT2, PAT3};
            4'hF: m = {PAT2, PAT4};
            4'h3: m = {PAT3, PAT1};
            4'h6: m = {PAT3, PAT2};
            4'h9: m = {PAT3, PAT3};
            4'hE: m = {PAT3, PAT4};
            4'hA: m = {PAT4, PAT1};
            4'hB: m = {PAT4, PAT2};
            4'hC: m = {PAT4, PAT3};
            default: m = {PAT4, PAT4};
        endcase
        return m;
    endfunction

    assign scan_start = (Col == PAT1) && (col_prev_q != PAT1);
    assign cnt_inc    = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcol_d  = tcol_q;
        trow_d  = trow_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_valid && ready_q) begin
                    {tcol_d, trow_d} = key_map(key_code);
                    cnt_d   = '0;
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                if (scan_start) begin
                    if (cnt_inc == HOLD_CNT) begin
                        cnt_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_RELEASE: begin
                if (scan_start) begin
                    if (cnt_inc == GAP_CNT) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so Row drops on the edge that leaves PRESS.
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        row_d   = ((state_d == S_PRESS) && (Col == tcol_d)) ? trow_d : 4'hF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            col_prev_q <= 4'hF;
            row_q      <= 4'hF;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_prev_q <= Col;
            row_q      <= row_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        tcol_q <= tcol_d;
        trow_q <= trow_d;
    end

    assign Row       = row_q;
    assign key_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator: Col/key traces are checked cycle by cycle against
// an event-level model built from the key layout and scan-start counting.
module tb_keypad_emulator;

    localparam int HOLD = 2;
    localparam int GAP  = 2;
    localparam int MAXN = 2048;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] Col;
    logic [3:0] Row;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    keypad_emulator #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .Col(Col), .Row(Row), .busy(busy), .done(done)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0] col_a [MAXN];
    logic       vld_a [MAXN];
    logic [3:0] kc_a  [MAXN];
    logic [6:0] got_a [MAXN];
    logic [6:0] exp_a [MAXN];
    bit         ss_a  [MAXN];
    logic [3:0] last_col;

    // Physical keypad layout, [row][column].
    logic [3:0] layout [0:3][0:3] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                      '{4'h4, 4'h5, 4'h6, 4'hB},
                                      '{4'h7, 4'h8, 4'h9, 4'hC},
                                      '{4'h0, 4'hF, 4'hE, 4'hD}};

    function automatic logic [3:0] line_pat(input int idx);
        logic [3:0] one;
        one = 4'b1000;
        return ~(one >> idx);
    endfunction

    function automatic logic [7:0] key_pats(input logic [3:0] k);
        logic [7:0] r;
        r = 8'hFF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (layout[rr][cc] == k) r = {line_pat(cc), line_pat(rr)};
        return r;
    endfunction

    function automatic int nth_scan(input int from, input int count, input int n);
        int seen;
        seen = 0;
        for (int u = from; u < n; u++) begin
            if (ss_a[u]) begin
                seen++;
                if (seen == count) return u;
            end
        end
        return n;
    endfunction

    function automatic void fill_scan(input int from, input int to, input int slot, input int phase);
        for (int t = from; t < to; t++) col_a[t] = line_pat(((t + phase) / slot) % 4);
    endfunction

    function automatic void clear_req(input int n);
        for (int t = 0; t < n; t++) begin
            vld_a[t] = 1'b0;
            kc_a[t]  = 4'($urandom);
        end
    endfunction

    // Expected outputs per cycle: each accepted press spans from the accept edge to the
    // GAP-th scan start after the HOLD-th scan start that follows it.
    task automatic model(input int n);
        int t, a, h, g;
        logic [7:0] p;
        logic [3:0] rw;
        for (int i = 0; i < n; i++)
            ss_a[i] = (col_a[i] == 4'b0111) && (((i == 0) ? last_col : col_a[i-1]) != 4'b0111);
        t = 0;
        while (t < n) begin
            if (!vld_a[t]) begin
                exp_a[t] = {4'hF, 3'b100};
                t++;
            end else begin
                a = t;
                p = key_pats(kc_a[a]);
                h = nth_scan(a + 1, HOLD, n);
                g = (h < n) ? nth_scan(h + 1, GAP, n) : n;
                for (int u = a; u < n && u <= g; u++) begin
                    rw = (u < h && col_a[u] == p[7:4]) ? p[3:0] : 4'hF;
                    exp_a[u] = (u == g) ? {4'hF, 3'b101} : {rw, 3'b010};
                end
                t = g + 1;
            end
        end
    endtask

    task automatic run_trace(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            Col       = col_a[i];
            key_valid = vld_a[i];
            key_code  = kc_a[i];
            @(posedge clk);
            #1;
            got_a[i] = {Row, key_ready, busy, done};
        end
        model(n);
        last_col = col_a[n-1];
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL %s cycle %0d: Row/ready/busy/done got %b_%b expected %b_%b",
                         name, i, got_a[i][6:3], got_a[i][2:0], exp_a[i][6:3], exp_a[i][2:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            Col = 4'($urandom);
            key_valid = 1'($urandom);
            key_code = 4'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({Row, key_ready, busy, done} !== 7'b1111_100) begin
                failures++;
                $display("FAIL reset cycle %0d: got %b_%b%b%b expected 1111_100", i, Row, key_ready, busy, done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        Col = 4'hF;
        key_valid = 1'b0;
        last_col = 4'hF;
    endtask

    task automatic test_single_press();
        clear_req(500);
        fill_scan(0, 500, 16, $urandom_range(0, 63));
        vld_a[3] = 1'b1;
        kc_a[3]  = 4'h5;
        run_trace("press_key5", 500);
    endtask

    task automatic test_illegal_col();
        logic [3:0] opts [7];
        opts = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0000, 4'b1111, 4'b0011};
        clear_req(700);
        for (int s = 0; s < 300; s += 8) begin
            logic [3:0] c;
            c = opts[$urandom_range(0, 6)];
            if (c == 4'b0011) c = 4'($urandom);
            for (int t = s; t < s + 8; t++) col_a[t] = c;
        end
        fill_scan(300, 700, 16, 0);
        vld_a[1] = 1'b1;
        kc_a[1]  = 4'h1;
        run_trace("illegal_col_key1", 700);
    endtask

    task automatic test_busy_ignored();
        clear_req(1000);
        fill_scan(0, 1000, 8, $urandom_range(0, 31));
        vld_a[2] = 1'b1;
        kc_a[2]  = 4'h3;
        for (int t = 10; t < 150; t++) begin
            vld_a[t] = ($urandom_range(0, 3) == 0);
            kc_a[t]  = 4'hA;
        end
        for (int t = 400; t < 420; t++) begin
            vld_a[t] = 1'b1;
            kc_a[t]  = 4'hA;
        end
        run_trace("busy_ignored", 1000);
    endtask

    task automatic test_key_sweep();
        for (int k = 0; k < 16; k++) begin
            clear_req(420);
            fill_scan(0, 420, $urandom_range(4, 16), $urandom_range(0, 63));
            for (int t = 0; t < 3; t++) begin
                vld_a[t] = 1'b1;
                kc_a[t]  = 4'(k);
            end
            run_trace($sformatf("sweep_key%0h", k), 420);
        end
    endtask

    task automatic test_back_to_back();
        clear_req(1800);
        fill_scan(0, 1800, $urandom_range(2, 8), $urandom_range(0, 31));
        for (int t = 0; t < 1300; t++) vld_a[t] = 1'b1;
        run_trace("back_to_back", 1800);
    endtask

    task automatic test_reset_mid_press();
        @(negedge clk);
        key_code = 4'h9; key_valid = 1'b1; Col = 4'hF;
        @(posedge clk);
        #1;
        checks++;
        if ({key_ready, busy} !== 2'b01) begin
            failures++;
            $display("FAIL accept_key9: ready/busy got %b%b expected 01", key_ready, busy);
        end
        @(negedge clk);
        key_valid = 1'b0; Col = 4'b1101;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (Row !== 4'b1101) begin
            failures++;
            $display("FAIL key9_row: Row got %b expected 1101", Row);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({Row, key_ready, busy, done} !== 7'b1111_100) begin
            failures++;
            $display("FAIL reset_mid_press: got %b_%b%b%b expected 1111_100", Row, key_ready, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            Col = line_pat((i / 8) % 4);
            @(posedge clk);
            #1;
            checks++;
            if ({Row, key_ready, busy, done} !== 7'b1111_100) begin
                failures++;
                $display("FAIL after_abort cycle %0d: got %b_%b%b%b expected 1111_100", i, Row, key_ready, busy, done);
            end
        end
        last_col = Col;
    endtask

    initial begin
        rst_n     = 1'b0;
        Col       = 4'hF;
        key_valid = 1'b0;
        key_code  = 4'h0;
        last_col  = 4'hF;
        test_reset();
        test_single_press();
        test_illegal_col();
        test_busy_ignored();
        test_key_sweep();
        test_back_to_back();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
